// File: rtl/fp_pkg.sv
// Shared types and IEEE-754 single-precision constants for the FP divider.
package fp_pkg;
    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        NORMALIZE,
        DONE
    } state_t;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    // Magnitude patterns (sign excluded) for the special results.
    localparam logic [EXP_W+MAN_W-1:0] ZERO = '0;
    localparam logic [EXP_W+MAN_W-1:0] INF  = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
endpackage

// File: rtl/fp_mant_div.sv
// Restoring mantissa divider: one quotient bit per step, MSB first.
module fp_mant_div
    import fp_pkg::*;
#(
    parameter int ITER = 25
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              load,
    input  logic              step,
    input  logic [MAN_W:0]    dividend,
    input  logic [MAN_W:0]    divisor,
    output logic [ITER-1:0]   quotient,
    output logic              last
);
    localparam int CW = $clog2(ITER);

    logic [MAN_W+1:0] r_rem;
    logic [ITER-1:0]  r_quo;
    logic [CW-1:0]    r_cnt;
    logic             w_ge;
    logic [MAN_W:0]   w_diff;

    // rem stays below 2*divisor, so a successful subtraction always fits in MAN_W+1 bits.
    assign w_ge   = r_rem >= {1'b0, divisor};
    assign w_diff = r_rem[MAN_W:0] - divisor;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= '0;
        end else if (load) begin
            r_rem <= {1'b0, dividend};
            r_quo <= '0;
            r_cnt <= '0;
        end else if (step) begin
            r_rem <= w_ge ? {w_diff, 1'b0} : {r_rem[MAN_W:0], 1'b0};
            r_quo <= {r_quo[ITER-2:0], w_ge};
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign quotient = r_quo;
    assign last     = step && (r_cnt == CW'(ITER - 1));
endmodule

// File: rtl/fp_divide.sv
// Fixed-latency IEEE-754 single-precision divider with truncation rounding.
module fp_divide #(
    parameter int BIAS = 127,
    parameter int ITER = 25
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] quotient_o,
    output logic        div_by_zero_o
);
    import fp_pkg::*;

    state_t                   r_state, w_state_next;
    logic                     w_load, w_step, w_last;
    logic [ITER-1:0]          w_q;
    logic                     r_sa, r_sb;
    logic [EXP_W-1:0]         r_ea, r_eb;
    logic [MAN_W-1:0]         r_mb;
    logic [EXP_W+MAN_W-1:0]   r_res, w_res;
    logic                     r_dbz_pend, w_dbz;
    logic [31:0]              r_quotient;
    logic                     r_done, r_dbz;
    logic signed [9:0]        w_exp;
    logic [MAN_W-1:0]         w_mant;

    fp_mant_div #(.ITER(ITER)) u_mant (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .load     (w_load),
        .step     (w_step),
        .dividend ({1'b1, a_i[MAN_W-1:0]}),
        .divisor  ({1'b1, r_mb}),
        .quotient (w_q),
        .last     (w_last)
    );

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_load       = 1'b1;
                    w_state_next = DIVIDE;
                end
            end
            DIVIDE: begin
                w_step = 1'b1;
                if (w_last) w_state_next = NORMALIZE;
            end
            NORMALIZE: w_state_next = DONE;
            DONE:      w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    // Special cases override the normalized result; a zero divisor wins over a zero dividend.
    always_comb begin
        w_exp  = 10'(r_ea) - 10'(r_eb) + 10'(BIAS) - 10'(!w_q[ITER-1]);
        w_mant = w_q[ITER-1] ? w_q[ITER-2 -: MAN_W] : w_q[ITER-3 -: MAN_W];
        w_res  = {w_exp[EXP_W-1:0], w_mant};
        w_dbz  = 1'b0;
        if (r_eb == '0) begin
            w_res = INF;
            w_dbz = 1'b1;
        end else if (r_ea == '0) begin
            w_res = ZERO;
        end else if (w_exp >= 10'sd255) begin
            w_res = INF;
        end else if (w_exp <= 10'sd0) begin
            w_res = ZERO;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state    <= IDLE;
            r_sa       <= 1'b0;
            r_sb       <= 1'b0;
            r_ea       <= '0;
            r_eb       <= '0;
            r_mb       <= '0;
            r_res      <= '0;
            r_dbz_pend <= 1'b0;
            r_quotient <= '0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            if (w_load) begin
                r_sa <= a_i[EXP_W+MAN_W];
                r_ea <= a_i[EXP_W+MAN_W-1 -: EXP_W];
                r_sb <= b_i[EXP_W+MAN_W];
                r_eb <= b_i[EXP_W+MAN_W-1 -: EXP_W];
                r_mb <= b_i[MAN_W-1:0];
            end
            if (r_state == NORMALIZE) begin
                r_res      <= w_res;
                r_dbz_pend <= w_dbz;
            end
            if (r_state == DONE) begin
                r_quotient <= {r_sa ^ r_sb, r_res};
                r_dbz      <= r_dbz_pend;
                r_done     <= 1'b1;
            end
        end
    end

    assign busy_o        = (r_state != IDLE);
    assign done_o        = r_done;
    assign quotient_o    = r_quotient;
    assign div_by_zero_o = r_dbz;
endmodule

// File: doc/fp_divide.md
FP_DIVIDE -- requirements
Module: fp_divide

Interface
REQ-001: Parameter BIAS, default 127, IEEE-754 single-precision exponent bias.
REQ-002: Parameter ITER, default 25, number of quotient bits produced, one per cycle.
REQ-003: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004: reset_ni  input  1  asynchronous, active-low reset.
REQ-005: start_i  input  1  request; accepted only when in IDLE.
REQ-006: a_i  input  32  dividend, IEEE-754 single.
REQ-007: b_i  input  32  divisor, IEEE-754 single.
REQ-008: busy_o  output  1  high in every state except IDLE.
REQ-009: done_o  output  1  one-cycle pulse; quotient_o is valid in that cycle.
REQ-010: quotient_o  output  32  a/b result; held from done_o until the next accepted start.
REQ-011: div_by_zero_o  output  1  sticky flag for the last result; updated with done_o.

Function
REQ-012: The FSM shall have the states IDLE, DIVIDE, NORMALIZE and DONE.
REQ-013: Transitions shall be IDLE->DIVIDE on start_i, DIVIDE->NORMALIZE after ITER iterations, NORMALIZE->DONE, and DONE->IDLE unconditionally.
REQ-014: On accept, a_i and b_i shall be registered, and the iteration counter and remainder shall be initialised.
REQ-015: start_i shall be ignored while busy_o=1, and in-flight operands shall not change.
REQ-016: The mantissa path shall be restoring division of {1,ma} by {1,mb}, using a 25-bit remainder.
REQ-017: Each DIVIDE cycle shall produce one quotient bit, MSB first, as follows: if rem>=div then rem=(rem-div)<<1 and bit=1; else rem<<=1 and bit=0.
REQ-018: q[24]=1 means the quotient is in [1,2); the mantissa shall be q[23:1] and the exponent ea-eb+BIAS.
REQ-019: q[24]=0 means the quotient is in [0.5,1); the mantissa shall be q[22:0] and the exponent ea-eb+BIAS-1.
REQ-020: The exponent shall be computed in 10-bit signed arithmetic to avoid wrap-around.
REQ-021: Rounding shall be truncation toward zero, with no sticky or guard bits.
REQ-022: Sign shall be sa XOR sb for all results, including special cases.
REQ-023: eb=0 (zero divisor) shall give {sign,8'hFF,23'h0} with div_by_zero_o=1, and this takes priority over REQ-024.
REQ-024: ea=0 with eb!=0 shall give {sign,31'h0}.
REQ-025: A computed exponent >=255 shall give signed infinity; a computed exponent <=0 shall give signed zero.
REQ-026: Denormal inputs shall be treated as zero; NaN/Inf inputs shall not be handled specially.
REQ-027: Latency shall be fixed: done_o shall pulse exactly ITER+2 cycles after the accepting edge, for every operand including special cases.
REQ-028: Back-to-back operation: start_i asserted in the cycle after done_o shall be accepted, since the FSM is then in IDLE.

Reset
REQ-029: reset_ni=0 shall immediately force IDLE and clear busy_o, done_o, div_by_zero_o, quotient_o, remainder, counter and operand registers.
REQ-030: A reset during DIVIDE or NORMALIZE shall abort the operation and produce no done_o pulse.
REQ-031: After release, the first rising edge with start_i=1 shall be accepted.

Structure
REQ-032: Shared package fp_pkg shall hold the state_t enum, the field widths (EXP_W=8, MAN_W=23), the BIAS constant, and the special-value constants ZERO and INF.
REQ-033: One sub-module, fp_mant_div, shall hold the remainder, quotient shift register and iteration counter, with ports load, step, divisor, quotient and last.
REQ-034: fp_divide shall hold the FSM, exponent/sign logic, special-case detection and normalization.

Verification
REQ-035: 0x40C00000 / 0x40000000 (6/2) -> quotient_o 0x40400000, done_o at cycle 27, div_by_zero_o=0.
REQ-036: 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAA (truncated), done_o at cycle 27.
REQ-037: 0xBF800000 / 0x3F000000 (-1/0.5) -> 0xC0000000; then start_i the cycle after done_o with 0x00000000 / 0x40A00000 -> 0x00000000.
REQ-038: 0x3F800000 / 0x00000000 -> 0x7F800000 with div_by_zero_o=1; 0x7F000000 / 0x00800000 -> 0x7F800000 with div_by_zero_o=0.
REQ-039: start_i pulsed at cycle 5 of a busy operation with different operands -> ignored, and the original result is unchanged.
REQ-040: reset_ni low at cycle 10 of DIVIDE -> all outputs 0 immediately, no done_o, next start_i produces a correct result.
